// File: rtl/wb_write_queue.sv
// Register-file writeback arbiter: primary pipeline writes pass straight through,
// long-latency writes wait in a small FIFO. Optional macro WB_BYPASS_EN adds same-cycle secondary bypass.
module wb_write_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pri_we,
  input  logic [4:0]               pri_waddr,
  input  logic [31:0]              pri_wdata,
  input  logic                     sec_valid,
  output logic                     sec_ready,
  input  logic [4:0]               sec_waddr,
  input  logic [31:0]              sec_wdata,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     waw_hit
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic        empty;
  logic        full;
  logic        pri_ok;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] pend_next;

  always_comb begin
    empty     = (count == '0);
    full      = (count == FULL_COUNT);
    pri_ok    = pri_we && (pri_waddr != '0);
    sec_ready = !rst && !full && ((sec_waddr == '0) || !pend_mask[sec_waddr]);
`ifdef WB_BYPASS_EN
    bypass    = empty && !pri_ok && sec_valid && sec_ready && (sec_waddr != '0);
`else
    bypass    = 1'b0;
`endif
    push      = sec_valid && sec_ready && (sec_waddr != '0) && !bypass;
    pop       = !pri_ok && !empty;
    waw_hit   = !rst && pri_ok && pend_mask[pri_waddr];

    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (pri_ok) begin
        rf_we    = 1'b1;
        rf_waddr = pri_waddr;
        rf_wdata = pri_wdata;
      end else if (!empty) begin
        rf_we    = 1'b1;
        rf_waddr = addr_mem[rd_ptr];
        rf_wdata = data_mem[rd_ptr];
      end else if (bypass) begin
        rf_we    = 1'b1;
        rf_waddr = sec_waddr;
        rf_wdata = sec_wdata;
      end
    end

    // Clear before set: sec_ready guarantees the pushed address differs from the popped one.
    pend_next = pend_mask;
    if (pop)
      pend_next[addr_mem[rd_ptr]] = 1'b0;
    if (push)
      pend_next[sec_waddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pend_mask <= '0;
    end else begin
      pend_mask <= pend_next;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_mem[wr_ptr] <= sec_waddr;
      data_mem[wr_ptr] <= sec_wdata;
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed vector table for the documented sequences,
// then random traffic checked against a queue-based reference model.
module tb_wb_write_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          pri_we;
  logic [4:0]    pri_waddr;
  logic [31:0]   pri_wdata;
  logic          sec_valid;
  logic          sec_ready;
  logic [4:0]    sec_waddr;
  logic [31:0]   sec_wdata;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [31:0]   pend_mask;
  logic [CW-1:0] count;
  logic          waw_hit;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .pri_we    (pri_we),
    .pri_waddr (pri_waddr),
    .pri_wdata (pri_wdata),
    .sec_valid (sec_valid),
    .sec_ready (sec_ready),
    .sec_waddr (sec_waddr),
    .sec_wdata (sec_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask),
    .count     (count),
    .waw_hit   (waw_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic          pw;
    logic [4:0]    pa;
    logic [31:0]   pd;
    logic          sv;
    logic [4:0]    sa;
    logic [31:0]   sd;
    logic          e_ready;
    logic          e_we;
    logic [4:0]    e_waddr;
    logic [31:0]   e_wdata;
    logic [31:0]   e_pend;
    logic [CW-1:0] e_count;
    logic          e_waw;
  } vec_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic r, logic pw, logic [4:0] pa, logic [31:0] pd,
                              logic sv, logic [4:0] sa, logic [31:0] sd,
                              logic e_ready, logic e_we, logic [4:0] e_waddr,
                              logic [31:0] e_wdata, logic [31:0] e_pend,
                              int e_count, logic e_waw);
    vec_t v;
    v.r = r; v.pw = pw; v.pa = pa; v.pd = pd; v.sv = sv; v.sa = sa; v.sd = sd;
    v.e_ready = e_ready; v.e_we = e_we; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_pend = e_pend; v.e_count = CW'(e_count); v.e_waw = e_waw;
    return v;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].a] = 1'b1;
    return m;
  endfunction

  // Expected outputs from the queue contents and this cycle's inputs.
  function automatic vec_t predict(vec_t v);
    vec_t e = v;
    logic [31:0] m = model_mask();
    logic pri_ok = v.pw && (v.pa != 0);
    e.e_pend  = m;
    e.e_count = CW'(q.size());
    e.e_ready = 1'b0; e.e_we = 1'b0; e.e_waddr = '0; e.e_wdata = '0; e.e_waw = 1'b0;
    if (!v.r) begin
      e.e_ready = (q.size() < DEPTH) && ((v.sa == 0) || !m[v.sa]);
      e.e_waw   = pri_ok && m[v.pa];
      if (pri_ok) begin
        e.e_we = 1'b1; e.e_waddr = v.pa; e.e_wdata = v.pd;
      end else if (q.size() > 0) begin
        e.e_we = 1'b1; e.e_waddr = q[0].a; e.e_wdata = q[0].d;
      end
    end
    return e;
  endfunction

  task automatic model_edge(vec_t v);
    vec_t e = predict(v);
    ent_t n;
    if (v.r) begin
      q.delete();
    end else begin
      if (!(v.pw && v.pa != 0) && q.size() > 0) void'(q.pop_front());
      if (v.sv && e.e_ready && v.sa != 0) begin
        n.a = v.sa; n.d = v.sd;
        q.push_back(n);
      end
    end
  endtask

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic step(vec_t v, int idx);
    rst = v.r; pri_we = v.pw; pri_waddr = v.pa; pri_wdata = v.pd;
    sec_valid = v.sv; sec_waddr = v.sa; sec_wdata = v.sd;
    @(negedge clk);
    chk("sec_ready", idx, 32'(sec_ready), 32'(v.e_ready));
    chk("rf_we",     idx, 32'(rf_we),     32'(v.e_we));
    chk("rf_waddr",  idx, 32'(rf_waddr),  32'(v.e_waddr));
    chk("rf_wdata",  idx, rf_wdata,       v.e_wdata);
    chk("pend_mask", idx, pend_mask,      v.e_pend);
    chk("count",     idx, 32'(count),     32'(v.e_count));
    chk("waw_hit",   idx, 32'(waw_hit),   32'(v.e_waw));
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; pri_we = 1'b0; pri_waddr = '0; pri_wdata = '0;
    sec_valid = 1'b0; sec_waddr = '0; sec_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    //                r  pw pa  pd         sv sa sd            rdy we wa wdata      pend  cnt waw
    tbl.push_back(mk(1, 0, 0,  0,         0, 0, 0,            0, 0, 0, 0,         0,    0, 0));
    tbl.push_back(mk(0, 0, 0,  0,         1, 5, 32'hAA,       1, 0, 0, 0,         0,    0, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 1, 5, 32'hAA,    32'h20, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 0, 0, 0,         0,    0, 0));
    // fill to DEPTH behind a busy primary port, then drain in order
    tbl.push_back(mk(0, 1, 10, 32'h100,   1, 1, 32'h11,       1, 1, 10, 32'h100,  0,    0, 0));
    tbl.push_back(mk(0, 1, 10, 32'h101,   1, 2, 32'h22,       1, 1, 10, 32'h101,  32'h2, 1, 0));
    tbl.push_back(mk(0, 1, 10, 32'h102,   1, 3, 32'h33,       1, 1, 10, 32'h102,  32'h6, 2, 0));
    tbl.push_back(mk(0, 1, 10, 32'h103,   1, 4, 32'h44,       1, 1, 10, 32'h103,  32'hE, 3, 0));
    tbl.push_back(mk(0, 1, 10, 32'h104,   1, 5, 32'h55,       0, 1, 10, 32'h104,  32'h1E, 4, 0));
    tbl.push_back(mk(0, 0, 0,  0,         1, 5, 32'h55,       0, 1, 1, 32'h11,    32'h1E, 4, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 1, 2, 32'h22,    32'h1C, 3, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 1, 3, 32'h33,    32'h18, 2, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 1, 4, 32'h44,    32'h10, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 0, 0, 0,         0,    0, 0));
    // duplicate destination blocked until the first drains
    tbl.push_back(mk(0, 1, 10, 32'h200,   1, 7, 32'h77,       1, 1, 10, 32'h200,  0,    0, 0));
    tbl.push_back(mk(0, 1, 10, 32'h201,   1, 7, 32'h78,       0, 1, 10, 32'h201,  32'h80, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         1, 7, 32'h78,       0, 1, 7, 32'h77,    32'h80, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         1, 7, 32'h78,       1, 0, 0, 0,         0,    0, 0));
    // primary write-after-write onto a pending register
    tbl.push_back(mk(0, 1, 7,  32'h300,   0, 0, 0,            1, 1, 7, 32'h300,   32'h80, 1, 1));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 1, 7, 32'h78,    32'h80, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 0, 0, 0,         0,    0, 0));
    // r0 writes on both ports are discarded
    tbl.push_back(mk(0, 1, 10, 32'h400,   1, 3, 32'h33,       1, 1, 10, 32'h400,  0,    0, 0));
    tbl.push_back(mk(0, 1, 0,  32'h500,   0, 0, 0,            1, 1, 3, 32'h33,    32'h8, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         1, 0, 32'hDEAD,     1, 0, 0, 0,         0,    0, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 0, 0, 0,         0,    0, 0));
    // reset with three entries queued
    tbl.push_back(mk(0, 1, 10, 32'h600,   1, 1, 32'h61,       1, 1, 10, 32'h600,  0,    0, 0));
    tbl.push_back(mk(0, 1, 10, 32'h601,   1, 2, 32'h62,       1, 1, 10, 32'h601,  32'h2, 1, 0));
    tbl.push_back(mk(0, 1, 10, 32'h602,   1, 3, 32'h63,       1, 1, 10, 32'h602,  32'h6, 2, 0));
    tbl.push_back(mk(1, 1, 10, 32'h603,   1, 4, 32'h64,       0, 0, 0, 0,         32'hE, 3, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 0, 0, 0,         0,    0, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 0, 0, 0,         0,    0, 0));
    // six pushes with overlapping pops wrap both pointers
    tbl.push_back(mk(0, 0, 0,  0,         1, 1, 32'h71,       1, 0, 0, 0,         0,    0, 0));
    tbl.push_back(mk(0, 0, 0,  0,         1, 2, 32'h72,       1, 1, 1, 32'h71,    32'h2, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         1, 3, 32'h73,       1, 1, 2, 32'h72,    32'h4, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         1, 4, 32'h74,       1, 1, 3, 32'h73,    32'h8, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         1, 5, 32'h75,       1, 1, 4, 32'h74,    32'h10, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         1, 6, 32'h76,       1, 1, 5, 32'h75,    32'h20, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 1, 6, 32'h76,    32'h40, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,         0, 0, 0,            1, 0, 0, 0,         0,    0, 0));

    q.delete();
    foreach (tbl[i]) step(tbl[i], i);

    for (int i = 0; i < 3000; i++) begin
      v.r  = (i == 0) || ($urandom_range(99) == 0);
      v.pw = ($urandom_range(9) < 4);
      v.pa = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
      v.pd = $urandom;
      v.sv = ($urandom_range(9) < 6);
      v.sa = 5'($urandom_range(7));
      v.sd = $urandom;
      step(predict(v), 1000 + i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
